mem_port_arbiter: RTL

- Shares one single-port, variable-latency memory between the instruction-fetch requester and the data (load/store) requester of the pipelined RV32I core.
- Grants one requester at a time and drives the memory handshake.
- Formats load data (byte/halfword extract plus sign/zero extension) and generates store byte enables and lane-shifted write data.
- Its done pulses are what the pipeline uses to release fetch and memory-stage stalls.

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters; define MEM_ARB_RR_EN for round-robin arbitration
module mem_port_arbiter #(
  parameter int DATA_LEN     = 32,
  parameter int MEM_ADDR_LEN = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req,
  input  logic [MEM_ADDR_LEN-1:0] i_addr,
  output logic                    i_done,
  output logic [DATA_LEN-1:0]     i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [2:0]              d_fn,
  input  logic [MEM_ADDR_LEN-1:0] d_addr,
  input  logic [DATA_LEN-1:0]     d_wdata,
  output logic                    d_done,
  output logic [DATA_LEN-1:0]     d_rdata,
  output logic                    d_err,
  output logic                    m_req,
  output logic                    m_we,
  output logic [MEM_ADDR_LEN-1:0] m_addr,
  output logic [3:0]              m_be,
  output logic [DATA_LEN-1:0]     m_wdata,
  input  logic                    m_ack,
  input  logic [DATA_LEN-1:0]     m_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
  state_t state_q, state_d;
  logic m_req_q, m_req_d, m_we_q, m_we_d, i_done_q, i_done_d, d_done_q, d_done_d;
  logic d_err_q, d_err_d, we_q, we_d;
  logic [MEM_ADDR_LEN-1:0] m_addr_q, m_addr_d;
  logic [3:0] m_be_q, m_be_d, be;
  logic [DATA_LEN-1:0] m_wdata_q, m_wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d, rep, fmt;
  logic [1:0] a_q, a_d;
  logic [2:0] fn_q, fn_d;
  logic pick_d, is_b, is_h, mis;
  logic [7:0] lb;
  logic [15:0] lh;
  assign is_b = d_fn[1:0] == 2'b00;
  assign is_h = d_fn[1:0] == 2'b01;
  assign mis  = (is_h && d_addr[0]) || (!is_b && !is_h && d_addr[1:0] != 2'b00);
  assign be   = is_b ? 4'b0001 << d_addr[1:0] : is_h ? 4'b0011 << d_addr[1:0] : 4'hF;
  assign rep  = is_b ? {4{d_wdata[7:0]}} : is_h ? {2{d_wdata[15:0]}} : d_wdata;
  assign lb   = m_rdata[{a_q, 3'b000} +: 8];
  assign lh   = m_rdata[{a_q[1], 4'b0000} +: 16];
  assign fmt  = we_q ? '0
              : fn_q[1:0] == 2'b00 ? {{24{~fn_q[2] & lb[7]}}, lb}
              : fn_q[1:0] == 2'b01 ? {{16{~fn_q[2] & lh[15]}}, lh}
              : m_rdata;
`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;
  assign pick_d = d_req && (!i_req || !last_q);
  assign last_d = (state_q == IDLE && (d_req || i_req)) ? pick_d : last_q;
  // remember who was granted last (1 = data) so contention alternates
  always_ff @(posedge clk)
    last_q <= reset ? 1'b0 : last_d;
`else
  assign pick_d = d_req;
`endif
  // arbitration, memory issue, response capture and done generation
  always_comb begin
    state_d   = state_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_be_d    = m_be_q;
    m_wdata_d = m_wdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    d_err_d   = d_err_q;
    a_d       = a_q;
    fn_d      = fn_q;
    we_d      = we_q;
    case (state_q)
      IDLE:
        if (pick_d) begin
          a_d  = d_addr[1:0];
          fn_d = d_fn;
          we_d = d_we;
          if (mis) begin
            state_d   = RESP;
            d_done_d  = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = '0;
          end else begin
            state_d   = BUSY_D;
            m_req_d   = 1'b1;
            m_we_d    = d_we;
            m_addr_d  = {d_addr[MEM_ADDR_LEN-1:2], 2'b00};
            m_be_d    = be;
            m_wdata_d = rep;
          end
        end else if (i_req) begin
          state_d   = BUSY_I;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = {i_addr[MEM_ADDR_LEN-1:2], 2'b00};
          m_be_d    = 4'hF;
          m_wdata_d = '0;
        end
      BUSY_I:
        if (m_ack) begin
          state_d   = RESP;
          i_done_d  = 1'b1;
          i_rdata_d = m_rdata;
          m_req_d   = 1'b0;
          m_we_d    = 1'b0;
          m_be_d    = 4'h0;
        end
      BUSY_D:
        if (m_ack) begin
          state_d   = RESP;
          d_done_d  = 1'b1;
          d_err_d   = 1'b0;
          d_rdata_d = fmt;
          m_req_d   = 1'b0;
          m_we_d    = 1'b0;
          m_be_d    = 4'h0;
        end
      RESP: state_d = IDLE;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_be_q    <= 4'h0;
      m_wdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      d_err_q   <= 1'b0;
      a_q       <= 2'b00;
      fn_q      <= 3'b000;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_be_q    <= m_be_d;
      m_wdata_q <= m_wdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      d_err_q   <= d_err_d;
      a_q       <= a_d;
      fn_q      <= fn_d;
      we_q      <= we_d;
    end
  end
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_be    = m_be_q;
  assign m_wdata = m_wdata_q;
  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign d_err   = d_err_q;
endmodule
